instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first fetched instruction.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard-unit hold; freezes PC and IF/ID.
REQ-005 redirect_br  input  1  branch taken, resolved in ID.
REQ-006 br_target  input  32  branch target byte address.
REQ-007 redirect_j  input  1  jump (j/jr), resolved in ID.
REQ-008 j_target  input  32  jump target byte address.
REQ-009 imem_addr  output  32  byte address to instruction ROM, equal to current PC; combinational.
REQ-010 imem_rdata  input  32  combinational ROM read data for imem_addr.
REQ-011 if_id_instr  output  32  registered fetched instruction.
REQ-012 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-013 if_id_valid  output  1  registered; 1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-014 FSM SHALL have two states: BOOT (entered on reset) and RUN.
REQ-015 BOOT SHALL last exactly one cycle after rst_n deasserts: PC held at RESET_PC, IF/ID written with a bubble, and then RUN is entered unconditionally.
REQ-016 In RUN with no stall and no redirect, each cycle SHALL set PC<=PC+4, if_id_instr<=imem_rdata, if_id_pc4<=PC+4 and if_id_valid<=1.
REQ-017 Fetch latency SHALL be one cycle: the word at PC appears on if_id_instr on the edge after PC is presented.
REQ-018 stall=1 with no redirect SHALL hold PC, if_id_instr, if_id_pc4 and if_id_valid unchanged.
REQ-019 redirect_j=1 SHALL set PC<=j_target and write a bubble to IF/ID (if_id_valid<=0, if_id_instr<=0).
REQ-020 redirect_br=1 with redirect_j=0 SHALL set PC<=br_target and write a bubble to IF/ID.
REQ-021 When both redirects are asserted, the jump SHALL take priority.
REQ-022 A redirect SHALL take priority over a simultaneous stall.
REQ-023 Redirect targets SHALL have bits [1:0] forced to 0 before being loaded into PC.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0); aliasing within the ROM is the ROM's concern.
REQ-025 Redirect, stall and data inputs SHALL be ignored in BOOT.

Reset
REQ-026 While rst_n=0: PC=RESET_PC, state=BOOT, if_id_instr=0, if_id_pc4=0, if_id_valid=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight fetch and any pending redirect immediately.

Configuration
REQ-028 With FETCH_STATS_EN defined: add outputs fetch_cnt[31:0] (increments on each REQ-016 cycle), stall_cnt[31:0] (increments on each REQ-018 cycle in RUN) and flush_cnt[31:0] (increments on each REQ-019/REQ-020 cycle); all reset to 0 and wrap at 2^32.
REQ-029 Without FETCH_STATS_EN: these ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-030 Reset release, ROM word0=32'h2008_0020 and word1=32'h2009_0037: BOOT cycle gives valid=0; next edge gives instr=32'h2008_0020, pc4=4, valid=1; next gives instr=32'h2009_0037, pc4=8.
REQ-031 stall held 2 cycles with PC=12: PC stays 12 and IF/ID is unchanged for both cycles; on release, the fetch resumes at 12.
REQ-032 redirect_br=1, br_target=32'h34 with stall=1 in the same cycle: next PC=32'h34, valid=0; the following edge loads the word at 0x34 with pc4=32'h38.
REQ-033 redirect_j=1 with j_target=32'h37 and redirect_br=1 with br_target=32'h10 together: PC=32'h34, valid=0.
REQ-034 PC=32'hFFFF_FFFC, no stall: pc4=0 and next PC=0.
REQ-035 rst_n pulsed low asynchronously mid-run, with FETCH_STATS_EN defined: outputs immediately reset, all counters read 0, and the REQ-030 sequence repeats.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencing and the IF/ID pipeline register.
// Optional fetch/stall/flush statistics counters are enabled with `define FETCH_STATS_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_br,
    input  logic [31:0] br_target,
    input  logic        redirect_j,
    input  logic [31:0] j_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        do_fetch, do_stall, do_flush;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        do_fetch = 1'b0;
        do_stall = 1'b0;
        do_flush = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_d    = RESET_PC;
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                // Jump beats branch, and any redirect beats a stall
                if (redirect_j || redirect_br) begin
                    do_flush = 1'b1;
                    pc_d     = redirect_j ? (j_target & 32'hFFFF_FFFC)
                                          : (br_target & 32'hFFFF_FFFC);
                    instr_d  = 32'h0;
                    pc4_d    = 32'h0;
                    valid_d  = 1'b0;
                end else if (stall) begin
                    do_stall = 1'b1;
                end else begin
                    do_fetch = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    instr_d  = imem_rdata;
                    pc4_d    = pc_q + 32'd4;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'b0, do_fetch};
        stall_cnt_d = stall_cnt_q + {31'b0, do_stall};
        flush_cnt_d = flush_cnt_q + {31'b0, do_flush};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = do_fetch ^ do_stall ^ do_flush;
`endif

endmodule
